// File: rtl/add_pipe_if.sv
// add_pipe_if: operand/result handshake bundle for the pipelined adder.
// "slave" is the adder's view; "master" is the producer/consumer view.
interface add_pipe_if #(
    parameter int WIDTH = 39
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport slave (
        input  in_valid, a, b, sub, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

    modport master (
        output in_valid, a, b, sub, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/add_pipe.sv
// add_pipe: pipelined two's-complement adder/subtractor.
// The WIDTH-bit carry chain is cut into STAGES chunks of CHUNK bits (the last
// chunk takes the remainder). Every stage has its own valid bit, so bubbles
// collapse and a stalled output lets upstream stages keep filling.
module add_pipe #(
    parameter int WIDTH  = 39,
    parameter int STAGES = 3
) (
    input  logic      clk,
    input  logic      rst,
    add_pipe_if.slave io
);
    localparam int CHUNK  = (WIDTH + STAGES - 1) / STAGES;
    localparam int LAST   = STAGES - 1;
    localparam int LAST_W = WIDTH - LAST * CHUNK;

    // Per-stage state: operands still to be added, partial sum, chunk carry,
    // and the operand sign bits needed for the final overflow flag.
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] a_d   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] b_d   [STAGES];
    logic [WIDTH-1:0] sum_q [STAGES];
    logic [WIDTH-1:0] sum_d [STAGES];
    logic             c_q   [STAGES];
    logic             c_d   [STAGES];
    logic             am_q  [STAGES];
    logic             am_d  [STAGES];
    logic             bm_q  [STAGES];
    logic             bm_d  [STAGES];
    logic             v_q   [STAGES];
    logic             v_d   [STAGES];
    logic             ovf_q;
    logic             ovf_d;

    logic             adv_s  [STAGES];
    logic             acc_s  [STAGES];
    logic             load_s [STAGES];
    logic             in_ready_s;

    // Backpressure chain: walk from the output back to stage 0, deciding which
    // stage may hand its data on (adv) and which may take new data (acc).
    always_comb begin
        logic rdy;
        rdy = io.out_ready;
        for (int k = LAST; k >= 0; k--) begin
            adv_s[k] = rdy;
            rdy      = !v_q[k] || rdy;
            acc_s[k] = rdy;
        end
    end

    assign in_ready_s = !rst && acc_s[0];

    // Load strobes and next valid bits: a stage fills when its predecessor hands
    // off into it, and empties when it hands off without being refilled.
    always_comb begin
        load_s[0] = io.in_valid && in_ready_s;
        for (int k = 1; k < STAGES; k++) begin
            load_s[k] = v_q[k-1] && adv_s[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            if (load_s[k]) begin
                v_d[k] = 1'b1;
            end else if (adv_s[k]) begin
                v_d[k] = 1'b0;
            end else begin
                v_d[k] = v_q[k];
            end
        end
    end

    // Chunk adders: stage k adds its slice of a and b_eff plus the incoming carry,
    // merging the slice result into the partial sum carried down the pipe.
    always_comb begin
        logic [WIDTH-1:0] src_a;
        logic [WIDTH-1:0] src_b;
        logic [WIDTH-1:0] src_sum;
        logic [WIDTH-1:0] new_sum;
        logic             src_c;
        logic             src_am;
        logic             src_bm;
        logic [WIDTH:0]   mask;
        logic [WIDTH:0]   op_a;
        logic [WIDTH:0]   op_b;
        logic [WIDTH:0]   part;
        logic [WIDTH:0]   part_hi;
        int               lo;
        int               w;
        int               prev;
        ovf_d = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            prev = (k > 0) ? k - 1 : 0;
            if (k == 0) begin
                // Subtract is folded in here: A - B - cin == A + ~B + ~cin.
                src_a   = io.a;
                src_b   = io.sub ? ~io.b : io.b;
                src_c   = io.sub ? ~io.cin : io.cin;
                src_sum = '0;
                src_am  = io.a[WIDTH-1];
                src_bm  = src_b[WIDTH-1];
            end else begin
                src_a   = a_q[prev];
                src_b   = b_q[prev];
                src_c   = c_q[prev];
                src_sum = sum_q[prev];
                src_am  = am_q[prev];
                src_bm  = bm_q[prev];
            end
            lo      = k * CHUNK;
            w       = (k == LAST) ? LAST_W : CHUNK;
            mask    = ({{WIDTH{1'b0}}, 1'b1} << w) - {{WIDTH{1'b0}}, 1'b1};
            op_a    = {1'b0, src_a >> lo} & mask;
            op_b    = {1'b0, src_b >> lo} & mask;
            part    = op_a + op_b + {{WIDTH{1'b0}}, src_c};
            part_hi = part >> w;
            new_sum = src_sum | ((part[WIDTH-1:0] & mask[WIDTH-1:0]) << lo);
            a_d[k]   = src_a;
            b_d[k]   = src_b;
            sum_d[k] = new_sum;
            c_d[k]   = part_hi[0];
            am_d[k]  = src_am;
            bm_d[k]  = src_bm;
            if (k == LAST) begin
                ovf_d = (src_am == src_bm) && (new_sum[WIDTH-1] != src_am);
            end else begin
                ovf_d = ovf_d;
            end
        end
    end

    // Pipeline registers: valid bits track flow every cycle; datapath registers
    // load only when their stage takes new data, so a stalled output holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k]   <= 1'b0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                sum_q[k] <= '0;
                c_q[k]   <= 1'b0;
                am_q[k]  <= 1'b0;
                bm_q[k]  <= 1'b0;
            end
            ovf_q <= 1'b0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= v_d[k];
                if (load_s[k]) begin
                    a_q[k]   <= a_d[k];
                    b_q[k]   <= b_d[k];
                    sum_q[k] <= sum_d[k];
                    c_q[k]   <= c_d[k];
                    am_q[k]  <= am_d[k];
                    bm_q[k]  <= bm_d[k];
                end
            end
            if (load_s[LAST]) begin
                ovf_q <= ovf_d;
            end
        end
    end

    assign io.in_ready  = in_ready_s;
    assign io.out_valid = v_q[LAST];
    assign io.sum       = sum_q[LAST];
    assign io.cout      = c_q[LAST];
    assign io.ovf       = ovf_q;
endmodule

// File: tb/tb_add_pipe.sv
// tb_add_pipe: directed vectors, reset cases, streaming and backpressure on a
// 39-bit/3-stage adder, plus streaming on (8,1), (8,8) and (64,5) variants.
module tb_add_pipe;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    add_pipe_if #(.WIDTH(39)) if_m   ();
    add_pipe_if #(.WIDTH(8))  if_s1  ();
    add_pipe_if #(.WIDTH(8))  if_s8  ();
    add_pipe_if #(.WIDTH(64)) if_s64 ();

    add_pipe #(.WIDTH(39), .STAGES(3)) dut_m   (.clk(clk), .rst(rst), .io(if_m));
    add_pipe #(.WIDTH(8),  .STAGES(1)) dut_s1  (.clk(clk), .rst(rst), .io(if_s1));
    add_pipe #(.WIDTH(8),  .STAGES(8)) dut_s8  (.clk(clk), .rst(rst), .io(if_s8));
    add_pipe #(.WIDTH(64), .STAGES(5)) dut_s64 (.clk(clk), .rst(rst), .io(if_s64));

    typedef struct {
        logic [38:0] a;
        logic [38:0] b;
        logic        sub;
        logic        cin;
        logic [38:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t         vecs [11];
    int           n_chk = 0;
    int           n_bad = 0;
    int           cyc = 0;
    logic         sb_en = 1'b0;
    logic         stream_on = 1'b0;
    int           first_in = -1;
    int           first_out = -1;
    int           gaps = 0;
    int           n_out_m = 0;
    int           n_out_1 = 0;
    int           n_out_8 = 0;
    int           n_out_64 = 0;
    logic [129:0] q_m [$];
    logic [129:0] q_1 [$];
    logic [129:0] q_8 [$];
    logic [129:0] q_64 [$];

    task automatic chk(input string name, input logic [129:0] got, input logic [129:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_bad++;
        $display("FAIL %s: result emitted with nothing outstanding", name);
    endtask

    function automatic logic bit_at(input logic [128:0] v, input int i);
        logic [128:0] t;
        t = v >> i;
        return t[0];
    endfunction

    function automatic logic [129:0] pk(input logic o, input logic c, input logic [127:0] s);
        return {o, c, s};
    endfunction

    // Reference: w-bit A+B+cin or A-B-cin with carry and signed overflow.
    function automatic logic [129:0] ref_add(input logic [127:0] a, input logic [127:0] b,
                                             input logic sub, input logic cin, input int w);
        logic [128:0] mask, ae, be, full;
        logic         ce, co, ov;
        logic [127:0] s;
        mask = (129'd1 << w) - 129'd1;
        ae   = {1'b0, a} & mask;
        be   = (sub ? ~{1'b0, b} : {1'b0, b}) & mask;
        ce   = sub ? ~cin : cin;
        full = ae + be + {128'd0, ce};
        co   = bit_at(full, w);
        s    = full[127:0] & mask[127:0];
        ov   = (bit_at(ae, w - 1) == bit_at(be, w - 1)) && (bit_at({1'b0, s}, w - 1) != bit_at(ae, w - 1));
        return {ov, co, s};
    endfunction

    // Main adder scoreboard plus first-result latency and gap tracking in streaming.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (sb_en && !rst) begin
            if (if_m.in_valid && if_m.in_ready) begin
                q_m.push_back(ref_add(128'(if_m.a), 128'(if_m.b), if_m.sub, if_m.cin, 39));
                if (stream_on && first_in < 0) first_in <= cyc;
            end
            if (if_m.out_valid && if_m.out_ready) begin
                if (q_m.size() == 0) fail_now("main_extra");
                else chk("main_result", pk(if_m.ovf, if_m.cout, 128'(if_m.sum)), q_m.pop_front());
                n_out_m <= n_out_m + 1;
                if (stream_on && first_out < 0) first_out <= cyc;
            end
            if (stream_on && first_out >= 0 && n_out_m < 100 && !if_m.out_valid) gaps <= gaps + 1;
        end
    end

    // Sweep scoreboards: each variant checked in order against the reference.
    always @(negedge clk) begin
        if (sb_en && !rst) begin
            if (if_s1.in_valid && if_s1.in_ready)
                q_1.push_back(ref_add(128'(if_s1.a), 128'(if_s1.b), if_s1.sub, if_s1.cin, 8));
            if (if_s1.out_valid && if_s1.out_ready) begin
                if (q_1.size() == 0) fail_now("sweep_8x1_extra");
                else chk("sweep_8x1", pk(if_s1.ovf, if_s1.cout, 128'(if_s1.sum)), q_1.pop_front());
                n_out_1 <= n_out_1 + 1;
            end
            if (if_s8.in_valid && if_s8.in_ready)
                q_8.push_back(ref_add(128'(if_s8.a), 128'(if_s8.b), if_s8.sub, if_s8.cin, 8));
            if (if_s8.out_valid && if_s8.out_ready) begin
                if (q_8.size() == 0) fail_now("sweep_8x8_extra");
                else chk("sweep_8x8", pk(if_s8.ovf, if_s8.cout, 128'(if_s8.sum)), q_8.pop_front());
                n_out_8 <= n_out_8 + 1;
            end
            if (if_s64.in_valid && if_s64.in_ready)
                q_64.push_back(ref_add(128'(if_s64.a), 128'(if_s64.b), if_s64.sub, if_s64.cin, 64));
            if (if_s64.out_valid && if_s64.out_ready) begin
                if (q_64.size() == 0) fail_now("sweep_64x5_extra");
                else chk("sweep_64x5", pk(if_s64.ovf, if_s64.cout, 128'(if_s64.sum)), q_64.pop_front());
                n_out_64 <= n_out_64 + 1;
            end
        end
    end

    task automatic apply_vec(input int i);
        int n;
        if_m.a        = vecs[i].a;
        if_m.b        = vecs[i].b;
        if_m.sub      = vecs[i].sub;
        if_m.cin      = vecs[i].cin;
        if_m.in_valid = 1'b1;
        #1;
        chk($sformatf("vec%0d_in_ready", i), 130'(if_m.in_ready), 130'd1);
        @(posedge clk); #1;
        if_m.in_valid = 1'b0;
        n = 1;
        while (!if_m.out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk($sformatf("vec%0d_latency", i), 130'(n), 130'd3);
        chk($sformatf("vec%0d_result", i), pk(if_m.ovf, if_m.cout, 128'(if_m.sum)),
            pk(vecs[i].ovf, vecs[i].cout, 128'(vecs[i].sum)));
        @(posedge clk); #1;
    endtask

    initial begin
        logic [127:0] ra, rb;
        logic [31:0]  rr;
        logic [129:0] snap;
        logic         have_snap, fire, seen;
        int           n_acc, n_before;

        vecs[0]  = '{39'h7F_FFFF_FFFF, 39'd1, 1'b0, 1'b0, 39'h00_0000_0000, 1'b1, 1'b0};
        vecs[1]  = '{39'h3F_FFFF_FFFF, 39'd1, 1'b0, 1'b0, 39'h40_0000_0000, 1'b0, 1'b1};
        vecs[2]  = '{39'd5, 39'd7, 1'b1, 1'b0, 39'h7F_FFFF_FFFE, 1'b0, 1'b0};
        vecs[3]  = '{39'd7, 39'd5, 1'b1, 1'b1, 39'h00_0000_0001, 1'b1, 1'b0};
        vecs[4]  = '{39'h00_0000_1FFF, 39'd1, 1'b0, 1'b0, 39'h00_0000_2000, 1'b0, 1'b0};
        vecs[5]  = '{39'h00_03FF_FFFF, 39'd0, 1'b0, 1'b1, 39'h00_0400_0000, 1'b0, 1'b0};
        vecs[6]  = '{39'h40_0000_0000, 39'h40_0000_0000, 1'b0, 1'b0, 39'h00_0000_0000, 1'b1, 1'b1};
        vecs[7]  = '{39'd0, 39'd1, 1'b1, 1'b0, 39'h7F_FFFF_FFFF, 1'b0, 1'b0};
        vecs[8]  = '{39'h40_0000_0000, 39'd1, 1'b1, 1'b0, 39'h3F_FFFF_FFFF, 1'b1, 1'b1};
        vecs[9]  = '{39'h00_0001_2345, 39'h00_0001_2345, 1'b1, 1'b0, 39'h00_0000_0000, 1'b1, 1'b0};
        vecs[10] = '{39'h2A_AAAA_AAAA, 39'h15_5555_5555, 1'b0, 1'b1, 39'h40_0000_0000, 1'b0, 1'b1};

        if_m.a = '0;   if_m.b = '0;   if_m.sub = 1'b0;   if_m.cin = 1'b0;   if_m.out_ready = 1'b1;
        if_s1.a = '0;  if_s1.b = '0;  if_s1.sub = 1'b0;  if_s1.cin = 1'b0;  if_s1.out_ready = 1'b1;
        if_s8.a = '0;  if_s8.b = '0;  if_s8.sub = 1'b0;  if_s8.cin = 1'b0;  if_s8.out_ready = 1'b1;
        if_s64.a = '0; if_s64.b = '0; if_s64.sub = 1'b0; if_s64.cin = 1'b0; if_s64.out_ready = 1'b1;
        if_s1.in_valid = 1'b0; if_s8.in_valid = 1'b0; if_s64.in_valid = 1'b0;

        // Reset held for two edges with in_valid high.
        rst = 1'b1;
        if_m.in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outputs", pk(if_m.ovf, if_m.cout, 128'(if_m.sum)), 130'd0);
        chk("rst_valid_ready", 130'({if_m.out_valid, if_m.in_ready}), 130'd0);
        rst = 1'b0;
        if_m.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("in_ready_after_rst", 130'(if_m.in_ready), 130'd1);
        chk("out_valid_after_rst", 130'(if_m.out_valid), 130'd0);

        // Directed vectors, one at a time, with latency.
        for (int i = 0; i < 11; i++) apply_vec(i);

        // Reset with an operand in flight: it must vanish.
        if_m.a = 39'd100; if_m.b = 39'd23; if_m.sub = 1'b0; if_m.cin = 1'b0;
        if_m.in_valid = 1'b1;
        @(posedge clk); #1;
        if_m.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (if_m.out_valid) seen = 1'b1;
        end
        @(posedge clk); #1;
        chk("midrst_no_output", 130'(seen), 130'd0);
        apply_vec(4);

        // Streaming: 100 back-to-back operands into every variant.
        sb_en = 1'b1;
        stream_on = 1'b1;
        for (int i = 0; i < 100; i++) begin
            ra = {$urandom, $urandom, $urandom, $urandom};
            rb = {$urandom, $urandom, $urandom, $urandom};
            rr = $urandom;
            if_m.a   = ra[38:0]; if_m.b   = rb[38:0]; if_m.sub   = rr[0]; if_m.cin   = rr[1];
            if_s1.a  = ra[7:0];  if_s1.b  = rb[7:0];  if_s1.sub  = rr[2]; if_s1.cin  = rr[3];
            if_s8.a  = ra[15:8]; if_s8.b  = rb[15:8]; if_s8.sub  = rr[4]; if_s8.cin  = rr[5];
            if_s64.a = ra[63:0]; if_s64.b = rb[63:0]; if_s64.sub = rr[6]; if_s64.cin = rr[7];
            if_m.in_valid = 1'b1; if_s1.in_valid = 1'b1; if_s8.in_valid = 1'b1; if_s64.in_valid = 1'b1;
            @(posedge clk); #1;
        end
        if_m.in_valid = 1'b0; if_s1.in_valid = 1'b0; if_s8.in_valid = 1'b0; if_s64.in_valid = 1'b0;
        for (int t = 0; t < 40 && (q_m.size() + q_1.size() + q_8.size() + q_64.size()) != 0; t++) begin
            @(posedge clk); #1;
        end
        stream_on = 1'b0;
        chk("stream_count_main", 130'(n_out_m), 130'd100);
        chk("stream_count_8x1", 130'(n_out_1), 130'd100);
        chk("stream_count_8x8", 130'(n_out_8), 130'd100);
        chk("stream_count_64x5", 130'(n_out_64), 130'd100);
        chk("stream_first_latency", 130'(first_out - first_in), 130'd3);
        chk("stream_gaps", 130'(gaps), 130'd0);

        // Backpressure: out_ready low for 6 cycles while offering operands.
        n_before = n_out_m;
        if_m.out_ready = 1'b0;
        ra = {$urandom, $urandom, $urandom, $urandom};
        if_m.a = ra[38:0]; if_m.b = ra[77:39]; if_m.sub = ra[100]; if_m.cin = ra[101];
        if_m.in_valid = 1'b1;
        n_acc = 0;
        have_snap = 1'b0;
        snap = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            fire = if_m.in_valid && if_m.in_ready;
            if (fire) n_acc++;
            if (if_m.out_valid) begin
                if (have_snap) chk("stall_stable", pk(if_m.ovf, if_m.cout, 128'(if_m.sum)), snap);
                else begin
                    snap = pk(if_m.ovf, if_m.cout, 128'(if_m.sum));
                    have_snap = 1'b1;
                end
            end
            @(posedge clk); #1;
            if (fire) begin
                ra = {$urandom, $urandom, $urandom, $urandom};
                if_m.a = ra[38:0]; if_m.b = ra[77:39]; if_m.sub = ra[100]; if_m.cin = ra[101];
            end
        end
        chk("bp_accepts", 130'(n_acc), 130'd3);
        chk("bp_in_ready_low", 130'(if_m.in_ready), 130'd0);
        chk("bp_out_valid_high", 130'(if_m.out_valid), 130'd1);
        if_m.in_valid = 1'b0;
        if_m.out_ready = 1'b1;
        for (int t = 0; t < 20 && q_m.size() != 0; t++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        chk("bp_drain_count", 130'(n_out_m - n_before), 130'd3);
        chk("bp_queue_empty", 130'(q_m.size()), 130'd0);
        chk("bp_idle_after_drain", 130'(if_m.out_valid), 130'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before the test completed");
        $fatal(1, "time limit");
    end
endmodule
